trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
Machine-mode trap/interrupt controller for the 3-stage RV32 pipeline.
- Detects enabled pending interrupts (external, timer) and MRET in the execute stage.
- Kills the execute-stage instruction and stalls fetch.
- Sequences the CSR-file writes (mepc, mcause, mstatus) through the single CSR write port, then redirects the PC.
- Sits between the execute stage, the CSR register file and the PC mux.

Parameters:
XLEN, 32, datapath/CSR width
MSTATUS_ADDR, 12'h300, mstatus CSR address
MEPC_ADDR, 12'h341, mepc CSR address
MCAUSE_ADDR, 12'h342, mcause CSR address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
irq_ext  in  1  external interrupt, level
irq_timer  in  1  timer interrupt, level
mstatus_in  in  XLEN  current mstatus (bit3 MIE, bit7 MPIE)
mie_in  in  XLEN  current mie (bit11 MEIE, bit7 MTIE)
mtvec_in  in  XLEN  current mtvec ([1:0] mode, [31:2] base)
mepc_in  in  XLEN  current mepc
ex_valid  in  1  execute stage holds a real instruction
ex_pc  in  XLEN  PC of execute-stage instruction
ex_is_mret  in  1  execute-stage instruction is MRET
flush_ex  out  1  kill execute-stage writeback/store
stall_if  out  1  hold PC and fetch register
csr_we  out  1  CSR write strobe
csr_waddr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
pc_redirect_valid  out  1  load PC from pc_redirect
pc_redirect  out  XLEN  redirect target
irq_ack  out  1  one-cycle pulse on trap entry completion
busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, TRAP_JUMP, RESTORE_STATUS, RET_JUMP. State encoding is free.
- Trap condition: take = ex_valid & mstatus_in[3] & ((irq_ext & mie_in[11]) | (irq_timer & mie_in[7])).
- Priority: external over timer.
- Cause values: external 32'h8000000B, timer 32'h80000007.
- IDLE, take=1:
  - flush_ex=1 combinationally in the same cycle.
  - Latch epc<=ex_pc and the cause.
  - Latch next_status <= mstatus_in with MPIE<=MIE and MIE<=0.
  - Next state SAVE_EPC.
- IDLE, take=0, ex_valid & ex_is_mret:
  - flush_ex=0; the MRET itself commits with no side effects.
  - Latch ret_status <= mstatus_in with MIE<=MPIE and MPIE<=1.
  - Latch target <= mepc_in.
  - Next state RESTORE_STATUS.
- Interrupt and MRET in the same cycle: the interrupt wins, and mepc becomes the PC of the MRET.
- ex_valid=0 (bubble): no trap is taken; the FSM waits in IDLE.
- SAVE_EPC: csr_we=1, csr_waddr=MEPC_ADDR, csr_wdata={epc[31:2],2'b00}.
- SAVE_CAUSE: csr_we=1, csr_waddr=MCAUSE_ADDR, csr_wdata=cause.
- SAVE_STATUS: csr_we=1, csr_waddr=MSTATUS_ADDR, csr_wdata=next_status.
- TRAP_JUMP:
  - pc_redirect_valid=1 and irq_ack=1.
  - pc_redirect = {base,2'b00} when mode==0.
  - pc_redirect = {base,2'b00} + 4*cause[30:0] when mode==1, with wrap-around modulo 2^XLEN.
  - Modes 2 and 3 are treated as mode 0.
  - mtvec is sampled in this state.
- RESTORE_STATUS: csr_we=1, csr_waddr=MSTATUS_ADDR, csr_wdata=ret_status.
- RET_JUMP: pc_redirect_valid=1, pc_redirect=target.
- All non-IDLE states step to the next state unconditionally:
  - SAVE_EPC → SAVE_CAUSE → SAVE_STATUS → TRAP_JUMP → IDLE
  - RESTORE_STATUS → RET_JUMP → IDLE
- Trap entry latency: detection at cycle N, redirect at N+4. MRET latency: detection at N, redirect at N+2.
- stall_if=1 and busy=1 in every non-IDLE state.
- In non-IDLE states, irq and mret inputs are ignored and flush_ex=0.
- Outputs not named for a state are 0 in that state, including csr_waddr and csr_wdata.
- Reset:
  - State goes to IDLE and all registers clear.
  - All outputs are 0 in the cycle after rst is sampled high.
  - Reset mid-sequence abandons it with no further CSR write or redirect.
  - A rst=1 cycle drives all outputs to 0, including a flush_ex that take would otherwise raise.
- Re-entry: after TRAP_JUMP, MIE=0 (as written by SAVE_STATUS) so a still-asserted level irq is not re-taken. The CSR file must present the updated mstatus by the IDLE cycle after TRAP_JUMP.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then irq_ext=0 and irq_timer=0 for 10 cycles → busy=0, csr_we=0, pc_redirect_valid=0 throughout.
2. External interrupt entry:
   - Stimulus: mstatus=32'h8, mie=32'h800, mtvec=32'h100, ex_pc=32'h40, irq_ext=1 at cycle N.
   - Response: flush_ex at N.
   - Writes: mepc=32'h40 at N+1, mcause=32'h8000000B at N+2, mstatus=32'h80 at N+3.
   - Redirect: pc_redirect=32'h100 with irq_ack at N+4.
3. Vectored timer with simultaneous irq:
   - Stimulus: mtvec=32'h201, irq_ext=1 with MEIE=0, irq_timer=1 with MTIE=1.
   - Response: mcause=32'h80000007, pc_redirect=32'h21C.
4. MRET:
   - Stimulus: mstatus=32'h80, mepc=32'h44, ex_is_mret=1 at N.
   - Response: flush_ex=0; mstatus write 32'h88 at N+1; pc_redirect=32'h44 at N+2.
   - Then irq_ext with MIE=1 is taken again.
5. Blocking conditions:
   - Interrupt with ex_valid=0 → no action until ex_valid=1.
   - Interrupt with MIE=0 → never taken.
   - irq and MRET together → trap taken with mepc = MRET PC.
6. Reset mid-sequence: rst at N+2 of a trap → next cycle busy=0, no mstatus write, no redirect.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer for the 3-stage RV32 pipeline: kills the execute-stage
// instruction, streams mepc/mcause/mstatus through the single CSR write port, then redirects the PC.
module trap_sequencer #(
   parameter int unsigned XLEN         = 32,
   parameter logic [11:0] MSTATUS_ADDR = 12'h300,
   parameter logic [11:0] MEPC_ADDR    = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic [XLEN-1:0] mstatus_in,
   input  logic [XLEN-1:0] mie_in,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic [XLEN-1:0] mepc_in,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_is_mret,
   output logic            flush_ex,
   output logic            stall_if,
   output logic            csr_we,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            pc_redirect_valid,
   output logic [XLEN-1:0] pc_redirect,
   output logic            irq_ack,
   output logic            busy
);

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_SAVE_EPC       = 3'd1,
      ST_SAVE_CAUSE     = 3'd2,
      ST_SAVE_STATUS    = 3'd3,
      ST_TRAP_JUMP      = 3'd4,
      ST_RESTORE_STATUS = 3'd5,
      ST_RET_JUMP       = 3'd6
   } state_e;

   localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, (XLEN-1)'(4'd11)};
   localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, (XLEN-1)'(4'd7)};
   localparam logic [XLEN-1:0] EPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

   state_e          state_q, state_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] status_q, status_d;
   logic [XLEN-1:0] target_q, target_d;

   logic            ext_en_s;
   logic            tmr_en_s;
   logic            take_s;
   logic [XLEN-1:0] base_pc_s;
   logic [XLEN-1:0] vec_pc_s;
   logic            unused_mie_s;

   assign ext_en_s  = irq_ext & mie_in[11];
   assign tmr_en_s  = irq_timer & mie_in[7];
   assign take_s    = ex_valid & mstatus_in[3] & (ext_en_s | tmr_en_s);
   assign base_pc_s = {mtvec_in[XLEN-1:2], 2'b00};
   // 4*cause[30:0] truncated to XLEN bits is cause[XLEN-3:0] shifted left by two.
   assign vec_pc_s  = base_pc_s + {cause_q[XLEN-3:0], 2'b00};
   assign unused_mie_s = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:0]};

   // State and latched trap context; a synchronous reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         epc_q    <= {XLEN{1'b0}};
         cause_q  <= {XLEN{1'b0}};
         status_q <= {XLEN{1'b0}};
         target_q <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         status_q <= status_d;
         target_q <= target_d;
      end
   end

   // Next-state and context capture; an interrupt beats an MRET in the same cycle.
   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      status_d = status_q;
      target_d = target_q;
      case (state_q)
         ST_IDLE: begin
            if (take_s) begin
               state_d     = ST_SAVE_EPC;
               epc_d       = ex_pc & EPC_MASK;
               cause_d     = ext_en_s ? CAUSE_EXT : CAUSE_TMR;
               status_d    = mstatus_in;
               status_d[7] = mstatus_in[3];
               status_d[3] = 1'b0;
            end else if (ex_valid && ex_is_mret) begin
               state_d     = ST_RESTORE_STATUS;
               status_d    = mstatus_in;
               status_d[3] = mstatus_in[7];
               status_d[7] = 1'b1;
               target_d    = mepc_in;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SAVE_EPC:       state_d = ST_SAVE_CAUSE;
         ST_SAVE_CAUSE:     state_d = ST_SAVE_STATUS;
         ST_SAVE_STATUS:    state_d = ST_TRAP_JUMP;
         ST_TRAP_JUMP:      state_d = ST_IDLE;
         ST_RESTORE_STATUS: state_d = ST_RET_JUMP;
         ST_RET_JUMP:       state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Output decode; a cycle with rst high forces every output low.
   always_comb begin
      flush_ex          = 1'b0;
      stall_if          = 1'b0;
      csr_we            = 1'b0;
      csr_waddr         = 12'h000;
      csr_wdata         = {XLEN{1'b0}};
      pc_redirect_valid = 1'b0;
      pc_redirect       = {XLEN{1'b0}};
      irq_ack           = 1'b0;
      busy              = 1'b0;
      if (rst) begin
         busy = 1'b0;
      end else begin
         stall_if = (state_q != ST_IDLE);
         busy     = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: flush_ex = take_s;
            ST_SAVE_EPC: begin
               csr_we    = 1'b1;
               csr_waddr = MEPC_ADDR;
               csr_wdata = epc_q;
            end
            ST_SAVE_CAUSE: begin
               csr_we    = 1'b1;
               csr_waddr = MCAUSE_ADDR;
               csr_wdata = cause_q;
            end
            ST_SAVE_STATUS: begin
               csr_we    = 1'b1;
               csr_waddr = MSTATUS_ADDR;
               csr_wdata = status_q;
            end
            ST_TRAP_JUMP: begin
               pc_redirect_valid = 1'b1;
               irq_ack           = 1'b1;
               pc_redirect       = (mtvec_in[1:0] == 2'b01) ? vec_pc_s : base_pc_s;
            end
            ST_RESTORE_STATUS: begin
               csr_we    = 1'b1;
               csr_waddr = MSTATUS_ADDR;
               csr_wdata = status_q;
            end
            ST_RET_JUMP: begin
               pc_redirect_valid = 1'b1;
               pc_redirect       = target_q;
            end
            default: flush_ex = 1'b0;
         endcase
      end
   end

endmodule
